readout_sequencer: RTL and testbench
====================================

Name: readout_sequencer

Overview:
- Frame-level controller for the pixel array and its readout path.
- Runs one frame per start request: pixel erase, exposure, ramp ADC conversion, then readout.
- Drives the read strobe that advances the one-hot read_select shift register and makes the memory handler latch each pixel pair.
- Throttles readout with a ready input from the downstream consumer and flags when each latched pixel pair is valid.

Parameters:
- ERASE_CYCLES, 4, number of cycles erase is held high.
- EXP_W, 8, width of the exposure_time input.
- CONV_STEPS, 256, ADC ramp length in cycles; adc_count width = $clog2(CONV_STEPS).
- NUM_READS, 4, read strobes per frame; equals the read_select width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- frame_reset  input  1  reset, asynchronous, active-high; clears the whole block.
- start  input  1  frame request, sampled only in IDLE.
- exposure_time  input  EXP_W  exposure length in cycles, latched when start is accepted.
- rd_ready  input  1  consumer can accept a pixel pair this cycle.
- erase  output  1  pixel erase phase.
- expose  output  1  pixel exposure phase.
- convert  output  1  ADC ramp active.
- adc_count  output  $clog2(CONV_STEPS)  ramp code broadcast to the pixel comparators.
- read  output  1  read strobe to the memory handler and the read_select shift register.
- data_valid  output  1  pixel pair outputs of the memory handler are valid.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset: async, active-high. State = IDLE; erase, expose, convert, read, data_valid, busy and frame_done = 0; adc_count = 0; internal counters = 0.
- States:
  - IDLE -> ERASE when start = 1 at an edge. exposure_time is latched on that edge; a value of 0 is clamped to 1.
  - ERASE: erase = 1 for exactly ERASE_CYCLES cycles, then EXPOSE.
  - EXPOSE: expose = 1 for exactly the latched number of cycles, then CONVERT.
  - CONVERT: convert = 1 for CONV_STEPS cycles. adc_count = 0 in the first CONVERT cycle and increments by 1 per cycle to CONV_STEPS-1, then READ.
  - READ: read = (state == READ) && rd_ready, combinational from the registered state. The read counter increments on each read cycle. The cycle that issues read number NUM_READS moves the FSM to DONE.
  - DONE: frame_done = 1 for one cycle, then IDLE.
- erase, expose, convert and busy decode from registered state only (glitch-free). adc_count is registered.
- After CONVERT, adc_count holds CONV_STEPS-1 until the next CONVERT entry resets it to 0.
- Readout timing:
  - data_valid = read delayed by exactly one cycle, aligned with the memory handler's registered pixel outputs.
  - data_valid may still be high in the DONE cycle.
  - rd_ready low in READ stalls without timeout; reads may be back-to-back or gapped.
  - rd_ready is ignored outside READ.
- start is ignored while busy; no queuing.
- start held high continuously starts a new frame on the first IDLE cycle after DONE.
- frame_reset mid-frame aborts immediately to IDLE with all outputs 0. The read_select register shares frame_reset, so readout realigns to read_select[0].
- Phase outputs are mutually exclusive; at most one of erase, expose, convert and read is high in any cycle.

Decomposition:
- Shared package cmos_pkg:
  - state enum (IDLE, ERASE, EXPOSE, CONVERT, READ, DONE);
  - default constants for ERASE_CYCLES, CONV_STEPS and NUM_READS, shared with the pixel array and the memory handler.
- Sub-module cycle_counter: loadable down-counter with done flag and async clear. One instance times ERASE, EXPOSE and CONVERT.
- adc_count and the read counter stay in the top level.

Test Plan:
- Nominal frame. Defaults, frame_reset released, start pulsed in cycle 0, exposure_time = 10, rd_ready = 1:
  - erase high cycles 1-4; expose 5-14; convert 15-270 with adc_count 0..255;
  - read 271-274; data_valid 272-275; frame_done cycle 275; busy low from 276.
- Backpressure. As above but rd_ready low in cycles 272-273 -> read in 271, 274, 275, 276; data_valid 272, 275, 276, 277; frame_done cycle 277.
- Exposure clamp. exposure_time = 0 -> expose high exactly 1 cycle (cycle 5); convert starts cycle 6.
- Start while busy. Start pulses in cycles 3 and 100 -> no effect; exactly one frame_done.
- Abort mid-frame. frame_reset asserted mid-CONVERT (adc_count = 37) -> all outputs 0 asynchronously. After release and a new start -> full frame with 4 reads starting at read_select[0].
- Back-to-back frames. start held high for 600 cycles -> second erase begins the cycle after the first frame_done + 1 (IDLE cycle); two frame_done pulses.

Source files
------------

// File: rtl/cmos_pkg.sv
// Shared types and default timing constants for the CMOS frame path.
// Used by the readout sequencer, pixel array and memory handler.
package cmos_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    READ,
    DONE
  } state_t;

  localparam int ERASE_CYCLES_DEF = 4;
  localparam int CONV_STEPS_DEF   = 256;
  localparam int NUM_READS_DEF    = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// Loadable down-counter; done_o is high while the count is zero.
// Ports: clk_i, clr_i (async clear), load_i/load_val_i, done_o.
module cycle_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/readout_sequencer.sv
// Frame controller: erase, expose, ramp-convert, then throttled readout.
// Ports: start/exposure_time in, rd_ready in, phase strobes, adc_count,
// read, data_valid, busy, frame_done out.
module readout_sequencer
  import cmos_pkg::*;
#(
  parameter int ERASE_CYCLES = ERASE_CYCLES_DEF,
  parameter int EXP_W        = 8,
  parameter int CONV_STEPS   = CONV_STEPS_DEF,
  parameter int NUM_READS    = NUM_READS_DEF
) (
  input  logic                          clk,
  input  logic                          frame_reset,
  input  logic                          start,
  input  logic [EXP_W-1:0]              exposure_time,
  input  logic                          rd_ready,
  output logic                          erase,
  output logic                          expose,
  output logic                          convert,
  output logic [$clog2(CONV_STEPS)-1:0] adc_count,
  output logic                          read,
  output logic                          data_valid,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int AW = $clog2(CONV_STEPS);
  localparam int RW = $clog2(NUM_READS + 1);
  localparam int CW = max3(EXP_W, AW, $clog2(ERASE_CYCLES + 1));

  state_t           state_q, state_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [AW-1:0]    adc_q, adc_d;
  logic [RW-1:0]    rd_cnt_q, rd_cnt_d;
  logic             dv_q;
  logic             cnt_load;
  logic [CW-1:0]    cnt_val;
  logic             cnt_done;

  // One counter times every fixed-length phase; each phase loads
  // length-1 on entry and exits on the cycle the count reaches zero.
  cycle_counter #(.W(CW)) u_cnt (
    .clk_i      (clk),
    .clr_i      (frame_reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .done_o     (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    adc_d    = adc_q;
    rd_cnt_d = rd_cnt_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ERASE;
          exp_d    = (exposure_time == '0)
                   ? EXP_W'(1) : exposure_time;
          cnt_load = 1'b1;
          cnt_val  = CW'(ERASE_CYCLES - 1);
        end
      end
      ERASE: begin
        if (cnt_done) begin
          state_d  = EXPOSE;
          cnt_load = 1'b1;
          cnt_val  = CW'(exp_q) - CW'(1);
        end
      end
      EXPOSE: begin
        if (cnt_done) begin
          state_d  = CONVERT;
          cnt_load = 1'b1;
          cnt_val  = CW'(CONV_STEPS - 1);
          adc_d    = '0;
        end
      end
      CONVERT: begin
        // Hold the last ramp code after the final step.
        if (cnt_done) state_d = READ;
        else          adc_d   = adc_q + 1'b1;
      end
      READ: begin
        if (rd_ready) begin
          if (rd_cnt_q == RW'(NUM_READS - 1)) begin
            rd_cnt_d = '0;
            state_d  = DONE;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge frame_reset) begin
    if (frame_reset) begin
      state_q  <= IDLE;
      exp_q    <= '0;
      adc_q    <= '0;
      rd_cnt_q <= '0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      adc_q    <= adc_d;
      rd_cnt_q <= rd_cnt_d;
      dv_q     <= read;
    end
  end

  assign erase      = (state_q == ERASE);
  assign expose     = (state_q == EXPOSE);
  assign convert    = (state_q == CONVERT);
  assign read       = (state_q == READ) && rd_ready;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign adc_count  = adc_q;
  assign data_valid = dv_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Scoreboard bench for readout_sequencer: directed frames with
// hand-timed expected phase windows and read/valid/done events.
module tb_readout_sequencer;

  logic       clk = 1'b0;
  logic       frame_reset;
  logic       start;
  logic [7:0] exposure_time;
  logic       rd_ready;
  logic       erase, expose, convert, read;
  logic       data_valid, busy, frame_done;
  logic [7:0] adc_count;

  readout_sequencer dut (
    .clk           (clk),
    .frame_reset   (frame_reset),
    .start         (start),
    .exposure_time (exposure_time),
    .rd_ready      (rd_ready),
    .erase         (erase),
    .expose        (expose),
    .convert       (convert),
    .adc_count     (adc_count),
    .read          (read),
    .data_valid    (data_valid),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    int e;
    int fd;
  } frame_t;

  int     now = 0;
  int     t0 = 0;
  bit     chk_en = 1'b0;
  int     adc_init = 0;
  int     errs = 0;
  int     checks = 0;
  frame_t frames[$];
  int     q_rd[$];
  int     q_dv[$];
  int     q_fd[$];

  always @(posedge clk) now <= now + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s rel=%0d got=%0d want=%0d",
               nm, now - t0, act, want);
    end
  endtask

  // Monitor: phase windows from the frame list, events from queues.
  always @(negedge clk) begin : mon
    int r, cs, ce, ma;
    logic me, mx, mc, mb;
    if (chk_en) begin
      r = now - t0;
      me = 0; mx = 0; mc = 0; mb = 0;
      ma = adc_init;
      foreach (frames[i]) begin
        cs = frames[i].s + 5 + frames[i].e;
        ce = cs + 255;
        if (r >= frames[i].s + 1 && r <= frames[i].s + 4) me = 1;
        if (r >= frames[i].s + 5 && r < cs) mx = 1;
        if (r >= cs && r <= ce) begin
          mc = 1;
          ma = r - cs;
        end else if (r > ce) begin
          ma = 255;
        end
        if (r >= frames[i].s + 1 && r <= frames[i].fd) mb = 1;
      end
      chk("erase", erase, me);
      chk("expose", expose, mx);
      chk("convert", convert, mc);
      chk("busy", busy, mb);
      chk("adc_count", adc_count, ma);
      chk("exclusive",
          $countones({erase, expose, convert, read}) > 1, 0);
      if (read) begin
        if (q_rd.size() == 0) chk("read_extra", r, -1);
        else chk("read_at", r, q_rd.pop_front());
      end
      if (data_valid) begin
        if (q_dv.size() == 0) chk("dv_extra", r, -1);
        else chk("dv_at", r, q_dv.pop_front());
      end
      if (frame_done) begin
        if (q_fd.size() == 0) chk("done_extra", r, -1);
        else chk("done_at", r, q_fd.pop_front());
      end
    end
  end

  task automatic run(input int ex, input int st_lo, input int st_hi,
                     input int sp1, input int sp2, input int ncyc,
                     input bit hold);
    @(posedge clk); #1;
    t0 = now;
    start = 1'b1;
    exposure_time = 8'(ex);
    rd_ready = 1'b1;
    chk_en = 1'b1;
    for (int k = 1; k < ncyc; k++) begin
      @(posedge clk); #1;
      start = (k == sp1) || (k == sp2) || (hold && k < 600);
      rd_ready = !(k >= st_lo && k <= st_hi);
      if (!hold) exposure_time = 8'hFF;
    end
  endtask

  task automatic finish_test();
    @(negedge clk); #1;
    start = 1'b0;
    chk("reads_left", q_rd.size(), 0);
    chk("valids_left", q_dv.size(), 0);
    chk("dones_left", q_fd.size(), 0);
    chk_en = 1'b0;
    frames.delete();
    q_rd.delete();
    q_dv.delete();
    q_fd.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_erase"}, erase, 0);
    chk({tag, "_expose"}, expose, 0);
    chk({tag, "_convert"}, convert, 0);
    chk({tag, "_read"}, read, 0);
    chk({tag, "_dv"}, data_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_adc"}, adc_count, 0);
  endtask

  task automatic nominal();
    frames.push_back('{s: 0, e: 10, fd: 275});
    q_rd = '{271, 272, 273, 274};
    q_dv = '{272, 273, 274, 275};
    q_fd = '{275};
    run(10, -1, -1, -1, -1, 285, 1'b0);
    finish_test();
  endtask

  initial begin
    frame_reset = 1'b1;
    start = 1'b0;
    rd_ready = 1'b1;
    exposure_time = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    frame_reset = 1'b0;

    adc_init = 0;
    nominal();

    adc_init = 255;
    frames.push_back('{s: 0, e: 10, fd: 277});
    q_rd = '{271, 274, 275, 276};
    q_dv = '{272, 275, 276, 277};
    q_fd = '{277};
    run(10, 272, 273, -1, -1, 290, 1'b0);
    finish_test();

    frames.push_back('{s: 0, e: 1, fd: 266});
    q_rd = '{262, 263, 264, 265};
    q_dv = '{263, 264, 265, 266};
    q_fd = '{266};
    run(0, -1, -1, -1, -1, 280, 1'b0);
    finish_test();

    frames.push_back('{s: 0, e: 10, fd: 275});
    q_rd = '{271, 272, 273, 274};
    q_dv = '{272, 273, 274, 275};
    q_fd = '{275};
    run(10, -1, -1, 3, 100, 600, 1'b0);
    finish_test();

    frames.push_back('{s: 0, e: 10, fd: 100000});
    run(10, -1, -1, -1, -1, 53, 1'b0);
    @(negedge clk); #2;
    chk("abort_adc", adc_count, 37);
    chk("abort_conv", convert, 1);
    chk_en = 1'b0;
    frame_reset = 1'b1;
    #1;
    chk_all_zero("abort");
    frames.delete();
    @(posedge clk);
    @(posedge clk); #1;
    frame_reset = 1'b0;
    adc_init = 0;
    nominal();

    adc_init = 255;
    frames.push_back('{s: 0, e: 10, fd: 275});
    frames.push_back('{s: 276, e: 10, fd: 551});
    frames.push_back('{s: 552, e: 10, fd: 100000});
    q_rd = '{271, 272, 273, 274, 547, 548, 549, 550};
    q_dv = '{272, 273, 274, 275, 548, 549, 550, 551};
    q_fd = '{275, 551};
    run(10, -1, -1, -1, -1, 600, 1'b1);
    finish_test();
    frame_reset = 1'b1;
    #1;
    chk_all_zero("final");
    @(posedge clk); #1;
    frame_reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
